// File: rtl/alu_pkg.sv
// Shared types for the ALU execute-stage back end: condition codes, flag
// positions, skid-buffer states and the writeback entry layout.
package alu_pkg;

    localparam int ALU_P    = 32;
    localparam int ALU_RD_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [ALU_P-1:0]    result;
        logic [ALU_RD_W-1:0] rd;
        logic                reg_wr;
        logic                mem_wr;
        logic                pc_src;
    } exec_entry_t;

endpackage

// File: rtl/alu_cond_check.sv
// Combinational ARM condition-code evaluation against an NZCV flag set.
module alu_cond_check
    import alu_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_cond_ex = 1'b1;
        case (cond_e'(i_cond))
            EQ:      o_cond_ex = w_z;
            NE:      o_cond_ex = !w_z;
            CS:      o_cond_ex = w_c;
            CC:      o_cond_ex = !w_c;
            MI:      o_cond_ex = w_n;
            PL:      o_cond_ex = !w_n;
            VS:      o_cond_ex = w_v;
            VC:      o_cond_ex = !w_v;
            HI:      o_cond_ex = w_c && !w_z;
            LS:      o_cond_ex = !w_c || w_z;
            GE:      o_cond_ex = (w_n == w_v);
            LT:      o_cond_ex = (w_n != w_v);
            GT:      o_cond_ex = !w_z && (w_n == w_v);
            LE:      o_cond_ex = w_z || (w_n != w_v);
            default: o_cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage back end: NZCV register, condition gating of side effects,
// squash counter and a 2-entry skid buffer towards writeback.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int P     = ALU_P,
    parameter int RD_W  = ALU_RD_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P-1:0]     alu_result,
    input  logic [3:0]       alu_flags,
    input  logic [3:0]       cond,
    input  logic [1:0]       flag_wr,
    input  logic             reg_wr_in,
    input  logic             mem_wr_in,
    input  logic             pc_src_in,
    input  logic [RD_W-1:0]  rd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P-1:0]     out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_reg_wr,
    output logic             out_mem_wr,
    output logic             out_pc_src,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] squash_cnt
);

    // Entry widths come from the package; P and RD_W must stay at those values.
    localparam logic [1:0] S_EMPTY = EMPTY;
    localparam logic [1:0] S_ONE   = ONE;
    localparam logic [1:0] S_TWO   = TWO;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_in_ready;
    exec_entry_t      r_out;
    exec_entry_t      r_skid;
    exec_entry_t      w_entry;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_squash;
    logic             w_cond_ex;
    logic             w_accept;

    alu_cond_check u_cond_check (
        .i_cond    (cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    assign w_accept = in_valid && r_in_ready;

    // Squashed instructions keep their slot so writeback order is preserved.
    always_comb begin
        w_entry        = '0;
        w_entry.result = alu_result;
        w_entry.rd     = rd_in;
        w_entry.reg_wr = reg_wr_in && w_cond_ex;
        w_entry.mem_wr = mem_wr_in && w_cond_ex;
        w_entry.pc_src = pc_src_in && w_cond_ex;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_next = S_ONE;
            S_ONE: begin
                if (w_accept && !out_ready)      w_state_next = S_TWO;
                else if (!w_accept && out_ready) w_state_next = S_EMPTY;
            end
            S_TWO:   if (out_ready) w_state_next = S_ONE;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b0;
            r_out      <= '0;
            r_skid     <= '0;
            r_flags    <= 4'b0000;
            r_squash   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != S_TWO);

            case (r_state)
                S_EMPTY: if (w_accept) r_out <= w_entry;
                S_ONE: begin
                    if (w_accept && out_ready) r_out  <= w_entry;
                    else if (w_accept)         r_skid <= w_entry;
                end
                S_TWO:   if (out_ready) r_out <= r_skid;
                default: ;
            endcase

            if (w_accept && w_cond_ex) begin
                if (flag_wr[1]) begin
                    r_flags[FLAG_N] <= alu_flags[FLAG_N];
                    r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
                end
                if (flag_wr[0]) begin
                    r_flags[FLAG_C] <= alu_flags[FLAG_C];
                    r_flags[FLAG_V] <= alu_flags[FLAG_V];
                end
            end

            if (w_accept && !w_cond_ex) r_squash <= r_squash + 1'b1;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_state != S_EMPTY);
    assign out_result = r_out.result;
    assign out_rd     = r_out.rd;
    assign out_reg_wr = r_out.reg_wr;
    assign out_mem_wr = r_out.mem_wr;
    assign out_pc_src = r_out.pc_src;
    assign flags_q    = r_flags;
    assign squash_cnt = r_squash;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: vector table for flag/condition behaviour,
// scoreboarded writeback stream, plus backpressure, reset and wrap sequences.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] alu_result = '0;
    logic [3:0]  alu_flags = '0;
    logic [3:0]  cond = '0;
    logic [1:0]  flag_wr = '0;
    logic        reg_wr_in = 1'b0;
    logic        mem_wr_in = 1'b0;
    logic        pc_src_in = 1'b0;
    logic [3:0]  rd_in = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_reg_wr, out_mem_wr, out_pc_src;
    logic [31:0] out_result;
    logic [3:0]  out_rd, flags_q;
    logic [15:0] squash_cnt;

    logic        b_in_ready, b_out_valid, b_out_reg_wr, b_out_mem_wr, b_out_pc_src;
    logic [31:0] b_out_result;
    logic [3:0]  b_out_rd, b_flags_q;
    logic [1:0]  b_squash_cnt;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_flags(alu_flags), .cond(cond), .flag_wr(flag_wr),
        .reg_wr_in(reg_wr_in), .mem_wr_in(mem_wr_in), .pc_src_in(pc_src_in), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_reg_wr(out_reg_wr), .out_mem_wr(out_mem_wr), .out_pc_src(out_pc_src),
        .flags_q(flags_q), .squash_cnt(squash_cnt)
    );

    alu_exec_stage #(.CNT_W(2)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .alu_result(alu_result), .alu_flags(alu_flags), .cond(cond), .flag_wr(flag_wr),
        .reg_wr_in(reg_wr_in), .mem_wr_in(mem_wr_in), .pc_src_in(pc_src_in), .rd_in(rd_in),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_result(b_out_result), .out_rd(b_out_rd),
        .out_reg_wr(b_out_reg_wr), .out_mem_wr(b_out_mem_wr), .out_pc_src(b_out_pc_src),
        .flags_q(b_flags_q), .squash_cnt(b_squash_cnt)
    );

    typedef struct {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        rw;
        logic        mw;
        logic        pc;
    } exp_t;

    typedef struct {
        logic [3:0]  cond;
        logic [1:0]  fwr;
        logic [3:0]  af;
        logic        rw;
        logic        mw;
        logic        pc;
        logic        pass;
        logic [3:0]  eflags;
        logic [15:0] esq;
    } vec_t;

    exp_t sb[$];
    exp_t pend;
    vec_t vecs[19];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                         input logic [31:0] res, input logic [3:0] rd,
                         input logic rw, input logic mw, input logic pc, input logic pass);
        in_valid    = 1'b1;
        cond        = c;
        flag_wr     = fw;
        alu_flags   = af;
        alu_result  = res;
        rd_in       = rd;
        reg_wr_in   = rw;
        mem_wr_in   = mw;
        pc_src_in   = pc;
        pend.result = res;
        pend.rd     = rd;
        pend.rw     = rw & pass;
        pend.mw     = mw & pass;
        pend.pc     = pc & pass;
    endtask

    // One clock: handshakes are judged on values settled before the edge.
    task automatic tick(output logic acc);
        logic        pop;
        logic [31:0] o_res;
        logic [3:0]  o_rd;
        logic        o_rw, o_mw, o_pc;
        exp_t        e;
        acc   = in_valid && in_ready;
        pop   = out_valid && out_ready;
        o_res = out_result;
        o_rd  = out_rd;
        o_rw  = out_reg_wr;
        o_mw  = out_mem_wr;
        o_pc  = out_pc_src;
        @(posedge clk);
        #1;
        if (pop) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_result", o_res, e.result);
                chk("out_rd", {28'd0, o_rd}, {28'd0, e.rd});
                chk("out_gates", {29'd0, o_rw, o_mw, o_pc}, {29'd0, e.rw, e.mw, e.pc});
                $display("xfer result=%0d rd=%0d reg_wr=%0b mem_wr=%0b pc_src=%0b",
                         o_res, o_rd, o_rw, o_mw, o_pc);
            end
        end
        if (acc) sb.push_back(pend);
    endtask

    task automatic drain(input string name);
        logic acc;
        in_valid = 1'b0;
        for (int k = 0; k < 8 && sb.size() > 0; k++) tick(acc);
        chk({name, "_drained"}, sb.size(), 32'd0);
        chk({name, "_out_valid_idle"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic do_reset(input string name);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #3;
        chk({name, "_rst_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_rst_flags"}, {28'd0, flags_q}, 32'd0);
        chk({name, "_rst_squash"}, {16'd0, squash_cnt}, 32'd0);
        chk({name, "_rst_squash_narrow"}, {30'd0, b_squash_cnt}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk({name, "_in_ready_after_release"}, {31'd0, in_ready}, 32'd1);
        $display("reset %s released", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;

        vecs[0]  = '{4'hE, 2'b11, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 16'd0};
        vecs[1]  = '{4'h0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 16'd0};
        vecs[2]  = '{4'h1, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 16'd1};
        vecs[3]  = '{4'hE, 2'b11, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 16'd1};
        vecs[4]  = '{4'hE, 2'b01, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001, 16'd1};
        vecs[5]  = '{4'hA, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001, 16'd1};
        vecs[6]  = '{4'h2, 2'b11, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 16'd2};
        vecs[7]  = '{4'hB, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 16'd3};
        vecs[8]  = '{4'hC, 2'b11, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 16'd3};
        vecs[9]  = '{4'h8, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 16'd4};
        vecs[10] = '{4'h9, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 16'd4};
        vecs[11] = '{4'hD, 2'b10, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 16'd4};
        vecs[12] = '{4'h4, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 16'd4};
        vecs[13] = '{4'h5, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 16'd5};
        vecs[14] = '{4'h6, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 16'd6};
        vecs[15] = '{4'h7, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 16'd6};
        vecs[16] = '{4'h3, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 16'd7};
        vecs[17] = '{4'hF, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 16'd7};
        vecs[18] = '{4'h0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010, 16'd8};

        out_ready = 1'b1;
        do_reset("initial");

        // Back-to-back vectors: each one sees the flags left by the previous.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].cond, vecs[i].fwr, vecs[i].af, 32'd100 + i, i[3:0],
                  vecs[i].rw, vecs[i].mw, vecs[i].pc, vecs[i].pass);
            tick(acc);
            chk($sformatf("vec%0d_accept", i), {31'd0, acc}, 32'd1);
            chk($sformatf("vec%0d_flags", i), {28'd0, flags_q}, {28'd0, vecs[i].eflags});
            chk($sformatf("vec%0d_squash", i), {16'd0, squash_cnt}, {16'd0, vecs[i].esq});
            if (i == 0) chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        end
        drain("table");

        // Backpressure: two entries fill out+skid, the third must wait.
        out_ready = 1'b0;
        drive(4'hE, 2'b00, 4'b0000, 32'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(acc);
        chk("bp_accept1", {31'd0, acc}, 32'd1);
        drive(4'hE, 2'b00, 4'b0000, 32'd2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(acc);
        chk("bp_accept2", {31'd0, acc}, 32'd1);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        drive(4'hE, 2'b00, 4'b0000, 32'd3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(acc);
            chk("bp_hold_no_accept", {31'd0, acc}, 32'd0);
            chk("bp_hold_out_result", out_result, 32'd1);
            chk("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 6 && !acc; k++) tick(acc);
        chk("bp_third_accepted", {31'd0, acc}, 32'd1);
        drain("bp");

        // Streaming: one in, one out per cycle with a single entry in flight.
        for (int i = 0; i < 8; i++) begin
            drive(4'hE, 2'b00, 4'b0000, 32'd200 + i, i[3:0], 1'b1, 1'b0, 1'b0, 1'b1);
            tick(acc);
            chk("stream_accept", {31'd0, acc}, 32'd1);
            chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_occupancy", sb.size(), 32'd1);
        end
        drain("stream");

        // Reset with both buffer slots occupied and nonzero flags/counter.
        out_ready = 1'b0;
        drive(4'hE, 2'b00, 4'b0000, 32'd55, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(acc);
        drive(4'h0, 2'b00, 4'b0000, 32'd56, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(acc);
        chk("pre_reset_full", {31'd0, in_ready}, 32'd0);
        do_reset("mid_traffic");
        out_ready = 1'b1;
        chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);

        // Squash wrap: the 2-bit counter instance must read 1 after five squashes.
        for (int i = 0; i < 5; i++) begin
            drive(4'h0, 2'b11, 4'b1111, 32'd300 + i, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
            tick(acc);
            if (i == 3) chk("wrap_narrow_at_zero", {30'd0, b_squash_cnt}, 32'd0);
        end
        chk("wrap_narrow_squash", {30'd0, b_squash_cnt}, 32'd1);
        chk("wrap_wide_squash", {16'd0, squash_cnt}, 32'd5);
        chk("wrap_flags_untouched", {28'd0, flags_q}, 32'd0);
        drain("wrap");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
